// File: rtl/mult_pkg.sv
// Shared helpers for the pipelined array multiplier: sizing functions and the
// partial-product generator used by the first adder stage.
package mult_pkg;

   localparam int unsigned MaxW = 32;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

   // Cycles from input accept to out_valid.
   function automatic int unsigned latency(input int unsigned w);
      return clog2(w) + 2;
   endfunction

   // b is zero-extended into MaxW bits by the caller; only the low w bits are meaningful.
   // In signed mode the top partial product carries negative weight, so it is negated.
   function automatic logic [2*MaxW-1:0] partial_product(input logic              a_bit,
                                                         input logic [MaxW-1:0] b,
                                                         input int unsigned     w,
                                                         input int unsigned     idx,
                                                         input logic            is_signed);
      logic [2*MaxW-1:0] ext;
      logic [2*MaxW-1:0] low_mask;
      logic              sign_bit;
      low_mask = (64'd1 << w) - 64'd1;
      ext      = {{MaxW{1'b0}}, b} & low_mask;
      sign_bit = is_signed && ((ext >> (w - 1)) != '0);
      if (sign_bit) begin
         ext = ext | ~low_mask;
      end
      ext = ext << idx;
      if (!a_bit) begin
         ext = '0;
      end else if (is_signed && (idx == w - 1)) begin
         ext = -ext;
      end
      return ext;
   endfunction

endpackage

// File: rtl/mult_tree_level.sv
// One registered level of the product adder tree: N_IN operands in, N_IN/2
// pairwise sums out, with a valid bit that moves in lockstep.
module mult_tree_level #(
   parameter int unsigned N_IN = 4,
   parameter int unsigned W    = 16
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      en_i,
   input  logic                      valid_i,
   input  logic [N_IN-1:0][W-1:0]    data_i,
   output logic                      valid_o,
   output logic [N_IN/2-1:0][W-1:0]  data_o
);

   logic [N_IN/2-1:0][W-1:0] sum_d;
   logic [N_IN/2-1:0][W-1:0] sum_q;
   logic                     valid_q;

   always_comb begin
      sum_d = '0;
      for (int i = 0; i < N_IN / 2; i++) begin
         sum_d[i] = data_i[2*i] + data_i[2*i+1];
      end
   end

   // Data only needs to move with en; the valid bit alone marks it meaningful.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         valid_q <= 1'b0;
      end else if (en_i) begin
         valid_q <= valid_i;
         sum_q   <= sum_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = sum_q;

endmodule

// File: rtl/pipelined_array_multiplier.sv
// Fixed-latency, one-per-cycle signed/unsigned array multiplier with a
// valid/ready handshake, global-stall backpressure and a pass-through tag.
module pipelined_array_multiplier
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned TAG_W = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic                 in_signed,
   input  logic [TAG_W-1:0]     in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_p,
   output logic [TAG_W-1:0]     out_tag
);

   localparam int unsigned LAT   = latency(WIDTH);
   localparam int unsigned PW    = 2 * WIDTH;
   localparam int unsigned HalfW = WIDTH / 2;
   localparam int unsigned NLvl  = LAT - 3;
   localparam int unsigned NNode = WIDTH - 1;

   logic en;

   logic               s0_vld_q;
   logic [WIDTH-1:0]   s0_a_q;
   logic [WIDTH-1:0]   s0_b_q;
   logic               s0_sgn_q;
   logic [TAG_W-1:0]   s0_tag_q;

   logic [PW-1:0]              pp [WIDTH];
   logic [HalfW-1:0][PW-1:0]   s1_sum_d;
   logic [HalfW-1:0][PW-1:0]   s1_sum_q;
   logic                       s1_vld_q;
   logic [TAG_W-1:0]           s1_tag_q;

   logic                 out_valid_q;
   logic [PW-1:0]        out_p_q;
   logic [TAG_W-1:0]     out_tag_q;

   // Tree nodes laid out level after level: the S1 sums first, then each level's outputs;
   // the final sum lands in the top node.
   wire [NNode-1:0][PW-1:0]   node;
   wire [NLvl:0]              lvl_vld;
   wire [NLvl:0][TAG_W-1:0]   lvl_tag;

   // Whole pipe stalls only when a finished result is being refused.
   assign en       = !(out_valid_q && !out_ready);
   assign in_ready = en && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         s0_vld_q <= 1'b0;
      end else if (en) begin
         s0_vld_q <= in_valid;
         s0_a_q   <= in_a;
         s0_b_q   <= in_b;
         s0_sgn_q <= in_signed;
         s0_tag_q <= in_tag;
      end
   end

   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         pp[i] = PW'(partial_product(s0_a_q[i], MaxW'(s0_b_q), WIDTH, i, s0_sgn_q));
      end
      s1_sum_d = '0;
      for (int j = 0; j < HalfW; j++) begin
         s1_sum_d[j] = pp[2*j] + pp[2*j+1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_vld_q <= 1'b0;
      end else if (en) begin
         s1_vld_q <= s0_vld_q;
         s1_sum_q <= s1_sum_d;
         s1_tag_q <= s0_tag_q;
      end
   end

   assign node[HalfW-1:0] = s1_sum_q;
   assign lvl_vld[0]      = s1_vld_q;
   assign lvl_tag[0]      = s1_tag_q;

   for (genvar l = 0; l < NLvl; l++) begin : g_lvl
      localparam int unsigned NIn    = WIDTH >> (l + 1);
      localparam int unsigned InOff  = WIDTH - (WIDTH >> l);
      localparam int unsigned OutOff = WIDTH - (WIDTH >> (l + 1));

      logic [TAG_W-1:0] tag_q;

      mult_tree_level #(
         .N_IN (NIn),
         .W    (PW)
      ) u_level (
         .clk_i   (clk),
         .reset_i (reset),
         .en_i    (en),
         .valid_i (lvl_vld[l]),
         .data_i  (node[InOff +: NIn]),
         .valid_o (lvl_vld[l+1]),
         .data_o  (node[OutOff +: NIn/2])
      );

      always_ff @(posedge clk) begin
         if (en) begin
            tag_q <= lvl_tag[l];
         end
      end

      assign lvl_tag[l+1] = tag_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_p_q     <= '0;
         out_tag_q   <= '0;
      end else if (en) begin
         out_valid_q <= lvl_vld[NLvl];
         out_p_q     <= node[NNode-1];
         out_tag_q   <= lvl_tag[NLvl];
      end
   end

   assign out_valid = out_valid_q;
   assign out_p     = out_p_q;
   assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_pipelined_array_multiplier.sv
// Directed bench for pipelined_array_multiplier at WIDTH=8 and WIDTH=16.
module tb_pipelined_array_multiplier;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        in_valid8, in_ready8, in_signed8, out_valid8, out_ready8;
   logic [7:0]  in_a8, in_b8;
   logic [3:0]  in_tag8, out_tag8;
   logic [15:0] out_p8;

   logic        in_valid16, in_ready16, in_signed16, out_valid16, out_ready16;
   logic [15:0] in_a16, in_b16;
   logic [3:0]  in_tag16, out_tag16;
   logic [31:0] out_p16;

   pipelined_array_multiplier #(.WIDTH(8), .TAG_W(4)) dut8 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid8), .in_ready(in_ready8), .in_a(in_a8), .in_b(in_b8),
      .in_signed(in_signed8), .in_tag(in_tag8),
      .out_valid(out_valid8), .out_ready(out_ready8), .out_p(out_p8), .out_tag(out_tag8)
   );

   pipelined_array_multiplier #(.WIDTH(16), .TAG_W(4)) dut16 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid16), .in_ready(in_ready16), .in_a(in_a16), .in_b(in_b16),
      .in_signed(in_signed16), .in_tag(in_tag16),
      .out_valid(out_valid16), .out_ready(out_ready16), .out_p(out_p16), .out_tag(out_tag16)
   );

   int checks = 0;
   int errors = 0;

   // Stimulus vectors and collected results for the 8-bit stream driver.
   logic [7:0]  va [32];
   logic [7:0]  vb [32];
   logic        vs [32];
   logic [3:0]  vt [32];
   int          nv;
   logic [15:0] rp [32];
   logic [3:0]  rt [32];
   int          rc [32];
   int          nr;
   logic        cyc_rdy [64];
   logic        cyc_ov  [64];
   logic [15:0] cyc_p   [64];
   logic [3:0]  cyc_t   [64];

   function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b,
                                          input logic s);
      logic signed [15:0] sa, sb;
      logic [15:0]        ua, ub;
      sa = {{8{a[7]}}, a};
      sb = {{8{b[7]}}, b};
      ua = {8'h00, a};
      ub = {8'h00, b};
      if (s) return sa * sb;
      return ua * ub;
   endfunction

   // Drives va/vb/vs/vt honouring in_ready; out_ready is low in cycles stall_lo..stall_hi.
   task automatic run_stream8(input int stall_lo, input int stall_hi, input int max_cyc);
      int idx;
      idx = 0;
      nr  = 0;
      for (int c = 0; c < max_cyc; c++) begin
         out_ready8 = !(c >= stall_lo && c <= stall_hi);
         if (idx < nv) begin
            in_valid8  = 1'b1;
            in_a8      = va[idx];
            in_b8      = vb[idx];
            in_signed8 = vs[idx];
            in_tag8    = vt[idx];
         end else begin
            in_valid8 = 1'b0;
         end
         #1;
         if (c < 64) begin
            cyc_rdy[c] = in_ready8;
            cyc_ov[c]  = out_valid8;
            cyc_p[c]   = out_p8;
            cyc_t[c]   = out_tag8;
         end
         if (in_valid8 && in_ready8) idx++;
         if (out_valid8 && out_ready8) begin
            if (nr < 32) begin
               rp[nr] = out_p8;
               rt[nr] = out_tag8;
               rc[nr] = c;
            end
            nr++;
         end
         @(posedge clk);
         #1;
      end
      in_valid8  = 1'b0;
      out_ready8 = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid8); end
      checks++; if (out_p8 !== 16'h0) begin errors++; $display("FAIL reset_out_p: got %h want 0000", out_p8); end
      checks++; if (out_tag8 !== 4'h0) begin errors++; $display("FAIL reset_out_tag: got %h want 0", out_tag8); end
      checks++; if (in_ready8 !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready8); end
      checks++; if (out_valid16 !== 1'b0) begin errors++; $display("FAIL reset_out_valid16: got %b want 0", out_valid16); end
      reset = 1'b0;
      #1;
      checks++; if (in_ready8 !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready8); end
      checks++; if (in_ready16 !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready16: got %b want 1", in_ready16); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_single_unsigned();
      nv = 1;
      va[0] = 8'hFF; vb[0] = 8'hFF; vs[0] = 1'b0; vt[0] = 4'd3;
      run_stream8(-1, -1, 12);
      checks++; if (nr !== 1) begin errors++; $display("FAIL single_count: got %0d want 1", nr); end
      checks++; if (rc[0] !== 5) begin errors++; $display("FAIL single_latency: got %0d want 5", rc[0]); end
      checks++; if (rp[0] !== 16'hFE01) begin errors++; $display("FAIL single_p: got %h want fe01", rp[0]); end
      checks++; if (rt[0] !== 4'd3) begin errors++; $display("FAIL single_tag: got %0d want 3", rt[0]); end
   endtask

   task automatic test_signed_b2b();
      logic [15:0] exp_p [4];
      nv = 4;
      va[0] = 8'h80; vb[0] = 8'h80; vs[0] = 1'b1; vt[0] = 4'd5; exp_p[0] = 16'h4000;
      va[1] = 8'hFF; vb[1] = 8'h7F; vs[1] = 1'b1; vt[1] = 4'd6; exp_p[1] = 16'hFF81;
      va[2] = 8'h00; vb[2] = 8'hFB; vs[2] = 1'b1; vt[2] = 4'd7; exp_p[2] = 16'h0000;
      va[3] = 8'h00; vb[3] = 8'hC8; vs[3] = 1'b0; vt[3] = 4'd8; exp_p[3] = 16'h0000;
      run_stream8(-1, -1, 16);
      checks++; if (nr !== 4) begin errors++; $display("FAIL signed_count: got %0d want 4", nr); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (rp[i] !== exp_p[i]) begin errors++; $display("FAIL signed_p[%0d]: got %h want %h", i, rp[i], exp_p[i]); end
         checks++; if (rt[i] !== vt[i]) begin errors++; $display("FAIL signed_tag[%0d]: got %0d want %0d", i, rt[i], vt[i]); end
         checks++; if (rc[i] !== 5 + i) begin errors++; $display("FAIL signed_cycle[%0d]: got %0d want %0d", i, rc[i], 5 + i); end
      end
   endtask

   task automatic test_throughput();
      nv = 20;
      for (int i = 0; i < 20; i++) begin
         va[i] = 8'($urandom);
         vb[i] = 8'($urandom);
         vs[i] = 1'($urandom);
         vt[i] = 4'(i);
      end
      run_stream8(-1, -1, 40);
      checks++; if (nr !== 20) begin errors++; $display("FAIL thru_count: got %0d want 20", nr); end
      for (int i = 0; i < 20; i++) begin
         checks++; if (rp[i] !== model8(va[i], vb[i], vs[i])) begin errors++; $display("FAIL thru_p[%0d]: got %h want %h", i, rp[i], model8(va[i], vb[i], vs[i])); end
         checks++; if (rt[i] !== vt[i]) begin errors++; $display("FAIL thru_tag[%0d]: got %0d want %0d", i, rt[i], vt[i]); end
         checks++; if (rc[i] !== 5 + i) begin errors++; $display("FAIL thru_cycle[%0d]: got %0d want %0d", i, rc[i], 5 + i); end
      end
   endtask

   task automatic test_backpressure();
      nv = 10;
      for (int i = 0; i < 10; i++) begin
         va[i] = 8'(8'h13 * (i + 1));
         vb[i] = 8'(8'hA7 - 8'(i * 5));
         vs[i] = 1'(i);
         vt[i] = 4'(i + 2);
      end
      // Output item 2 is presented in cycle 7 and refused until cycle 10.
      run_stream8(7, 9, 30);
      for (int c = 7; c <= 9; c++) begin
         checks++; if (cyc_rdy[c] !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, cyc_rdy[c]); end
         checks++; if (cyc_ov[c] !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %b want 1", c, cyc_ov[c]); end
         checks++; if (cyc_p[c] !== model8(va[2], vb[2], vs[2])) begin errors++; $display("FAIL bp_hold_p[%0d]: got %h want %h", c, cyc_p[c], model8(va[2], vb[2], vs[2])); end
         checks++; if (cyc_t[c] !== vt[2]) begin errors++; $display("FAIL bp_hold_tag[%0d]: got %0d want %0d", c, cyc_t[c], vt[2]); end
      end
      checks++; if (cyc_rdy[10] !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", cyc_rdy[10]); end
      checks++; if (nr !== 10) begin errors++; $display("FAIL bp_count: got %0d want 10", nr); end
      for (int i = 0; i < 10; i++) begin
         checks++; if (rp[i] !== model8(va[i], vb[i], vs[i])) begin errors++; $display("FAIL bp_p[%0d]: got %h want %h", i, rp[i], model8(va[i], vb[i], vs[i])); end
         checks++; if (rt[i] !== vt[i]) begin errors++; $display("FAIL bp_tag[%0d]: got %0d want %0d", i, rt[i], vt[i]); end
         checks++; if (rc[i] !== ((i < 2) ? 5 + i : 8 + i)) begin errors++; $display("FAIL bp_cycle[%0d]: got %0d want %0d", i, rc[i], (i < 2) ? 5 + i : 8 + i); end
      end
   endtask

   task automatic test_reset_midstream();
      int seen;
      logic [7:0] pa [3];
      logic [7:0] pb [3];
      pa[0] = 8'h11; pb[0] = 8'h22;
      pa[1] = 8'h80; pb[1] = 8'h80;
      pa[2] = 8'hFF; pb[2] = 8'hFF;
      out_ready8 = 1'b1;
      for (int c = 0; c < 3; c++) begin
         in_valid8 = 1'b1; in_a8 = pa[c]; in_b8 = pb[c]; in_signed8 = 1'(c); in_tag8 = 4'(c + 1);
         @(posedge clk);
         #1;
      end
      in_valid8 = 1'b0;
      reset = 1'b1;
      #1;
      checks++; if (in_ready8 !== 1'b0) begin errors++; $display("FAIL midrst_in_ready: got %b want 0", in_ready8); end
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b want 0", out_valid8); end
      checks++; if (out_p8 !== 16'h0) begin errors++; $display("FAIL midrst_out_p: got %h want 0000", out_p8); end
      checks++; if (in_ready8 !== 1'b1) begin errors++; $display("FAIL midrst_ready_after: got %b want 1", in_ready8); end
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         if (out_valid8) seen++;
         @(posedge clk);
         #1;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_leak: got %0d stale results want 0", seen); end
      nv = 1;
      va[0] = 8'h12; vb[0] = 8'h34; vs[0] = 1'b0; vt[0] = 4'd9;
      run_stream8(-1, -1, 12);
      checks++; if (nr !== 1) begin errors++; $display("FAIL midrst_new_count: got %0d want 1", nr); end
      checks++; if (rc[0] !== 5) begin errors++; $display("FAIL midrst_new_latency: got %0d want 5", rc[0]); end
      checks++; if (rp[0] !== 16'h03A8) begin errors++; $display("FAIL midrst_new_p: got %h want 03a8", rp[0]); end
      checks++; if (rt[0] !== 4'd9) begin errors++; $display("FAIL midrst_new_tag: got %0d want 9", rt[0]); end
   endtask

   task automatic test_width16();
      logic [31:0] gp [2];
      logic [3:0]  gt [2];
      int          gc [2];
      int          n;
      n = 0;
      out_ready16 = 1'b1;
      for (int c = 0; c < 16; c++) begin
         if (c == 0) begin
            in_valid16 = 1'b1; in_a16 = 16'hFFFF; in_b16 = 16'hFFFF; in_signed16 = 1'b0; in_tag16 = 4'd10;
         end else if (c == 1) begin
            in_valid16 = 1'b1; in_a16 = 16'h8000; in_b16 = 16'h7FFF; in_signed16 = 1'b1; in_tag16 = 4'd11;
         end else begin
            in_valid16 = 1'b0;
         end
         #1;
         if (out_valid16) begin
            if (n < 2) begin
               gp[n] = out_p16;
               gt[n] = out_tag16;
               gc[n] = c;
            end
            n++;
         end
         @(posedge clk);
         #1;
      end
      checks++; if (n !== 2) begin errors++; $display("FAIL w16_count: got %0d want 2", n); end
      checks++; if (gp[0] !== 32'hFFFE0001) begin errors++; $display("FAIL w16_unsigned_p: got %h want fffe0001", gp[0]); end
      checks++; if (gc[0] !== 6) begin errors++; $display("FAIL w16_latency: got %0d want 6", gc[0]); end
      checks++; if (gt[0] !== 4'd10) begin errors++; $display("FAIL w16_tag0: got %0d want 10", gt[0]); end
      checks++; if (gp[1] !== 32'hC0008000) begin errors++; $display("FAIL w16_signed_p: got %h want c0008000", gp[1]); end
      checks++; if (gc[1] !== 7) begin errors++; $display("FAIL w16_cycle1: got %0d want 7", gc[1]); end
      checks++; if (gt[1] !== 4'd11) begin errors++; $display("FAIL w16_tag1: got %0d want 11", gt[1]); end
   endtask

   initial begin
      reset = 1'b1;
      in_valid8 = 1'b0; in_a8 = '0; in_b8 = '0; in_signed8 = 1'b0; in_tag8 = '0; out_ready8 = 1'b1;
      in_valid16 = 1'b0; in_a16 = '0; in_b16 = '0; in_signed16 = 1'b0; in_tag16 = '0; out_ready16 = 1'b1;
      nv = 0;
      nr = 0;
      test_reset();
      test_single_unsigned();
      test_signed_b2b();
      test_throughput();
      test_backpressure();
      test_reset_midstream();
      test_width16();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipelined_array_multiplier.md
Name: pipelined_array_multiplier

Overview:
- Parametrised successor to the team's fixed 8-bit pipelined array multiplier.
- Operand width is generic. Signed or unsigned mode is selected per transaction.
- Has a valid/ready handshake with full backpressure and a pass-through tag.
- Sits between producer and consumer datapath stages as a one-result-per-cycle multiply unit with fixed latency.

Parameters:
- WIDTH, 8: operand width in bits. Must be a power of two, 4..32.
- TAG_W, 4: width of the sideband tag carried alongside each operation.
- LAT, clog2(WIDTH)+2: derived, not overridable. Cycles from input accept to out_valid.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  multiplier can accept this cycle
- in_a  in  WIDTH  multiplicand
- in_b  in  WIDTH  multiplier
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned
- in_tag  in  TAG_W  sideband, returned unchanged with the result
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_p  out  2*WIDTH  product
- out_tag  out  TAG_W  tag of this product

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset. All state changes only on rising clk.
- Reset values:
  - Every stage valid bit, out_valid, out_p and out_tag are 0.
  - in_ready is 0 while reset is high.
  - in_ready is 1 in the first cycle after reset deasserts.
- Pipeline has LAT register stages, each with its own valid bit:
  - S0: register a, b, signed and tag.
  - S1: form WIDTH partial products, add adjacent pairs, register WIDTH/2 sums.
  - S2..S(LAT-2): binary adder-tree levels, each halving the operand count.
  - S(LAT-1): output register driving out_p, out_tag and out_valid.
- Global enable: en = !(out_valid && !out_ready). in_ready = en.
  - When en=0, every stage holds its data and valid bit.
  - Bubbles (valid=0) advance normally when en=1. They are not compressed.
- Accept: in_valid && in_ready samples the inputs into S0.
  - Result appears on out_p exactly LAT cycles later, assuming no stall cycles in between.
  - Each stall cycle adds one cycle.
- Throughput is 1 per cycle when out_ready is held high. Output order equals input order.
- Output hold: while out_valid && !out_ready, out_p and out_tag hold stable.
- No combinational path from in_valid or in_a to outputs.
- in_ready depends combinationally only on out_valid and out_ready.
- Arithmetic:
  - Partial product i = b sign/zero-extended to 2*WIDTH, shifted left i, gated by a[i].
  - Unsigned: all partial products added.
  - Signed: b sign-extended, and partial product WIDTH-1 is subtracted (two's-complement negate) instead of added.
  - All tree adds are 2*WIDTH wide. The result is the exact product; no overflow is possible.
  - Mode is per operation, so mixed signed/unsigned streams are legal back-to-back.
- Boundary conditions:
  - a=0 or b=0: product is 0 in both modes.
  - Signed most-negative × most-negative: exact positive product, e.g. WIDTH=8 gives 0x4000.
  - Reset while stalled or mid-stream: all in-flight operations are discarded. No result from before reset ever appears.
  - in_valid with in_ready=0: input is not consumed; the producer must hold it.
  - out_ready high with out_valid low: no effect.

Decomposition:
- Package mult_pkg holds:
  - clog2 function
  - latency computation
  - helper that computes a partial product from (a bit, b, index, signed mode)
- Sub-module mult_tree_level: one registered adder-tree level.
  - Parameters: N_IN and W.
  - Takes N_IN operands, outputs N_IN/2 registered pairwise sums, with en and valid passthrough.
  - Instantiated clog2(WIDTH)-1 times by a generate loop in the top.

Test Plan:
1. WIDTH=8, unsigned, a=255, b=255, tag=3, out_ready=1 -> out_valid at cycle 5 after accept, out_p=0xFE01, out_tag=3.
2. WIDTH=8, signed: (-128,-128) -> 0x4000; (-1,127) -> 0xFF81; (0,-5) -> 0x0000; all issued back-to-back, results on consecutive cycles in order.
3. Throughput: 20 random mixed-mode pairs on consecutive cycles, out_ready=1 -> 20 results on 20 consecutive cycles starting at LAT, each matching the reference model.
4. Backpressure: fill pipeline, drop out_ready for 3 cycles -> in_ready=0 for those 3 cycles, out_p/out_tag stable, no loss or duplication; release -> stream resumes in order.
5. Reset mid-stream: 3 ops in flight, assert reset 1 cycle -> out_valid=0, out_p=0 next cycle; no pre-reset result ever emitted; new op after reset returns at LAT.
6. WIDTH=16: unsigned 0xFFFF×0xFFFF -> 0xFFFE0001 at 6 cycles; signed -32768×32767 -> 0xC0008000.
